// File: rtl/lcd_pkg.sv
// Shared constants and FSM state type for the LCD hex pager.
// ASCII codes, display geometry and pager states.
package lcd_pkg;

  localparam logic [7:0] CH_SPACE    = 8'h20;
  localparam logic [7:0] CH_COLON    = 8'h3A;
  localparam logic [7:0] HEX_BASE_LO = 8'h30;
  localparam logic [7:0] HEX_BASE_HI = 8'h37;

  localparam int LCD_CHARS = 32;
  localparam int LCD_COLS  = 16;

  typedef enum logic [1:0] {
    IDLE,
    SNAP,
    CONV,
    PUBLISH
  } state_t;

endpackage

// File: rtl/hex_to_ascii.sv
// Nibble to uppercase ASCII hex character.
// 0-9 map to '0'-'9', 10-15 map to 'A'-'F'.
module hex_to_ascii
  import lcd_pkg::*;
(
  input  logic [3:0] i_nib,
  output logic [7:0] o_char
);

  always_comb begin
    if (i_nib < 4'd10)
      o_char = HEX_BASE_LO + {4'd0, i_nib};
    else
      o_char = HEX_BASE_HI + {4'd0, i_nib};
  end

endmodule

// File: rtl/lcd_hex_pager.sv
// Pages NCH probe channels onto a 2x16 LCD string, rebuilt serially.
// Define LCD_PAGER_AUTO_PAGE_EN for timed automatic page rotation.
module lcd_hex_pager
  import lcd_pkg::*;
#(
  parameter int NCH           = 8,
  parameter int WIDTH         = 32,
  parameter int ROTATE_CYCLES = 50000000
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NCH*WIDTH-1:0] i_ch_data,
  input  logic                 i_force,
  input  logic                 i_page_next,
  output logic [3:0]           o_page_out,
  output logic [255:0]         o_str_out,
  output logic                 o_refresh,
  output logic                 o_busy
);

  localparam int PAGES = (NCH + 1) / 2;
  localparam int D     = WIDTH / 4;

  localparam logic [3:0] LAST_PG = 4'(PAGES - 1);
  localparam logic [3:0] DM1     = 4'(D - 1);
  localparam logic [3:0] LAST_DC = 4'(D + 1);
  localparam logic [4:0] NCH5    = 5'(NCH);

  localparam logic [255:0] SPACES =
    {LCD_CHARS{CH_SPACE}};

  state_t r_state;
  state_t w_state_nxt;

  logic [3:0]       r_page;
  logic [WIDTH-1:0] r_snap0;
  logic [WIDTH-1:0] r_snap1;
  logic             r_pend_force;
  logic             r_pend_pg;
  logic [4:0]       r_idx;
  logic [255:0]     r_buf;
  logic [255:0]     r_str;

  logic [WIDTH-1:0] w_ch [16];

  for (genvar c = 0; c < 16; c++) begin : g_ch
    if (c < NCH) begin : g_on
      assign w_ch[c] = i_ch_data[c*WIDTH +: WIDTH];
    end else begin : g_off
      assign w_ch[c] = '0;
    end
  end

  logic w_auto;

`ifdef LCD_PAGER_AUTO_PAGE_EN
  logic [31:0] r_rot;

  assign w_auto = (r_rot == 32'(ROTATE_CYCLES - 1));

  always_ff @(posedge clk) begin
    if (rst || i_page_next || w_auto)
      r_rot <= '0;
    else
      r_rot <= r_rot + 32'd1;
  end
`else
  assign w_auto = 1'b0;
`endif

  logic       w_pg_req;
  logic [3:0] w_page_nxt;
  logic       w_chg;
  logic       w_trig;

  assign w_pg_req = i_page_next | w_auto;

  assign w_page_nxt =
    !r_pend_pg          ? r_page :
    (r_page == LAST_PG) ? 4'd0   :
                          r_page + 4'd1;

  assign w_chg =
    (w_ch[{r_page[2:0], 1'b0}] != r_snap0) |
    (w_ch[{r_page[2:0], 1'b1}] != r_snap1);

  assign w_trig = r_pend_force | r_pend_pg |
                  i_force | w_pg_req | w_chg;

  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      IDLE:    if (w_trig) w_state_nxt = SNAP;
      SNAP:    w_state_nxt = CONV;
      CONV:    if (r_idx == 5'd31)
                 w_state_nxt = PUBLISH;
      PUBLISH: w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // Character idx: line = idx[4], column = idx[3:0].
  logic             w_line;
  logic [3:0]       w_col;
  logic [3:0]       w_cidx;
  logic [WIDTH-1:0] w_val;
  logic             w_exist;
  logic             w_in_rng;
  logic [3:0]       w_dig;
  logic [5:0]       w_sh;
  logic [3:0]       w_nib;
  logic [3:0]       w_hex_in;
  logic [7:0]       w_hex;
  logic [7:0]       w_char;
  logic [255:0]     w_buf_nxt;

  assign w_line   = r_idx[4];
  assign w_col    = r_idx[3:0];
  assign w_cidx   = {r_page[2:0], w_line};
  assign w_val    = w_line ? r_snap1 : r_snap0;
  assign w_exist  = {1'b0, w_cidx} < NCH5;
  assign w_in_rng = (w_col >= 4'd2) &&
                    (w_col <= LAST_DC);
  assign w_dig    = w_col - 4'd2;
  assign w_sh     = {DM1 - w_dig, 2'b00};
  assign w_nib    = 4'(w_val >> w_sh);
  assign w_hex_in = (w_col == 4'd0) ? w_cidx : w_nib;

  hex_to_ascii u_hex (
    .i_nib  (w_hex_in),
    .o_char (w_hex)
  );

  always_comb begin
    w_char = CH_SPACE;
    unique case (1'b1)
      w_exist && (w_col == 4'd0): w_char = w_hex;
      w_exist && (w_col == 4'd1): w_char = CH_COLON;
      w_exist && w_in_rng:        w_char = w_hex;
      default:                    w_char = CH_SPACE;
    endcase
  end

  always_comb begin
    w_buf_nxt = r_buf;
    w_buf_nxt[{~r_idx, 3'b000} +: 8] = w_char;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_page       <= '0;
      r_snap0      <= '0;
      r_snap1      <= '0;
      r_pend_force <= 1'b1;
      r_pend_pg    <= 1'b0;
      r_idx        <= '0;
      r_buf        <= SPACES;
      r_str        <= SPACES;
    end else begin
      // A request landing in SNAP survives the clear.
      r_pend_force <= (r_state == SNAP ? 1'b0 : r_pend_force)
                      | i_force;
      r_pend_pg    <= (r_state == SNAP ? 1'b0 : r_pend_pg)
                      | w_pg_req;
      if (r_state == SNAP) begin
        r_page  <= w_page_nxt;
        r_snap0 <= w_ch[{w_page_nxt[2:0], 1'b0}];
        r_snap1 <= w_ch[{w_page_nxt[2:0], 1'b1}];
        r_idx   <= '0;
      end
      if (r_state == CONV) begin
        r_buf <= w_buf_nxt;
        r_idx <= r_idx + 5'd1;
        if (r_idx == 5'd31)
          r_str <= w_buf_nxt;
      end
    end
  end

  assign o_page_out = r_page;
  assign o_str_out  = r_str;
  assign o_refresh  = (r_state == PUBLISH);
  assign o_busy     = (r_state != IDLE);

endmodule
